// File: rtl/pipelined_sklansky_adder_pkg.sv
// Shared constants and placement helpers for the pipelined Sklansky adder.
// Flags feature macro: SKLANSKY_ADDER_FLAGS_EN.
package pipelined_sklansky_adder_pkg;

  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Prefix boundary at which pipeline rank k (1-based) sits.
  function automatic int rank_level(
    input int k,
    input int levels,
    input int stages
  );
    return (k * levels) / (stages + 1);
  endfunction

  // Rank index (0-based) sitting at boundary b, or -1 for a plain wire.
  function automatic int rank_at(
    input int b,
    input int levels,
    input int stages
  );
    int r;
    r = -1;
    for (int k = 1; k <= stages; k++)
      if (rank_level(k, levels, stages) == b) r = k - 1;
    return r;
  endfunction

endpackage

// File: rtl/sklansky_prefix_level.sv
// One combinational Sklansky prefix level on (G,P) pairs.
// Bits with bit LEVEL set merge with the top of the lower half-block.
module sklansky_prefix_level #(
  parameter int INPUT_SIZE = 64,
  parameter int LEVEL = 0
) (
  input  logic [INPUT_SIZE-1:0] g_in,
  input  logic [INPUT_SIZE-1:0] p_in,
  output logic [INPUT_SIZE-1:0] g_out,
  output logic [INPUT_SIZE-1:0] p_out
);

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_bit
    if (((i >> LEVEL) & 1) == 1) begin : g_op
      localparam int J = ((i >> LEVEL) << LEVEL) - 1;
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[J]);
      assign p_out[i] = p_in[i] & p_in[J];
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/pipelined_sklansky_adder.sv
// Pipelined Sklansky adder/subtractor with valid/ready flow control.
// Optional flag outputs enabled by SKLANSKY_ADDER_FLAGS_EN.
module pipelined_sklansky_adder
  import pipelined_sklansky_adder_pkg::*;
#(
  parameter int INPUT_SIZE = 64,
  parameter int PIPE_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [INPUT_SIZE-1:0] A,
  input  logic [INPUT_SIZE-1:0] B,
  input  logic                  c_in,
  input  logic                  sub,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [INPUT_SIZE-1:0] S,
  output logic                  c_out
`ifdef SKLANSKY_ADDER_FLAGS_EN
  ,
  output logic                  zero_o,
  output logic                  negative_o,
  output logic                  overflow_o
`endif
);

  localparam int N = INPUT_SIZE;
  localparam int L = log2_ceil(N);
  localparam int PS = PIPE_STAGES;

  if (N < 2 || (1 << L) != N) begin : g_bad_size
    $error("INPUT_SIZE must be a power of two >= 2");
  end
  if (PS < 0 || PS > L) begin : g_bad_stages
    $error("PIPE_STAGES must lie in 0..log2(INPUT_SIZE)");
  end

  typedef struct packed {
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N-1:0] x;
    logic         c;
  } node_t;

  logic [PS:0]  v;
  logic [PS:0]  ld;
  logic [PS:0]  vin;
  logic [N-1:0] bx;
  logic         cx;

  assign bx = sub ? ~B : B;
  assign cx = sub ? ~c_in : c_in;

  // Load chain: a rank advances when empty or when its successor advances
  always_comb begin
    ld = '0;
    vin = '0;
    ld[PS] = !v[PS] || ready_i;
    for (int r = PS - 1; r >= 0; r--)
      ld[r] = !v[r] || ld[r+1];
    vin[0] = valid_i;
    for (int r = 1; r <= PS; r++)
      vin[r] = v[r-1];
  end

  assign ready_o = ld[0];
  assign valid_o = v[PS];

  // Valid bits move forward whenever their rank loads
  always_ff @(posedge clock) begin
    if (!reset_n) v <= '0;
    else
      for (int r = 0; r <= PS; r++)
        if (ld[r]) v[r] <= vin[r];
  end

  for (genvar b = 0; b <= L; b++) begin : g_bound
    localparam int R = rank_at(b, L, PS);
    logic [N-1:0] ig, ip, ix;
    logic         ic;
    logic [N-1:0] og, op, ox;
    logic         oc;

    if (b == 0) begin : g_src
      assign ig = A & bx;
      assign ip = A ^ bx;
      assign ix = A ^ bx;
      assign ic = cx;
    end else begin : g_chain
      assign ig = g_bound[b-1].g_lvl.lg;
      assign ip = g_bound[b-1].g_lvl.lp;
      assign ix = g_bound[b-1].ox;
      assign ic = g_bound[b-1].oc;
    end

    if (R >= 0) begin : g_rank
      node_t q;
      // Rank captures the partial prefix state only on a valid advance
      always_ff @(posedge clock) begin
        if (!reset_n) q <= '0;
        else if (ld[R] && vin[R])
          q <= '{g: ig, p: ip, x: ix, c: ic};
      end
      assign og = q.g;
      assign op = q.p;
      assign ox = q.x;
      assign oc = q.c;
    end else begin : g_wire
      assign og = ig;
      assign op = ip;
      assign ox = ix;
      assign oc = ic;
    end

    if (b < L) begin : g_lvl
      logic [N-1:0] lg, lp;
      sklansky_prefix_level #(
        .INPUT_SIZE(N),
        .LEVEL(b)
      ) u_level (
        .g_in (og),
        .p_in (op),
        .g_out(lg),
        .p_out(lp)
      );
    end
  end

  logic [N-1:0] fg, fp, fx, cy, s_d;
  logic         fc;

  assign fg = g_bound[L].og;
  assign fp = g_bound[L].op;
  assign fx = g_bound[L].ox;
  assign fc = g_bound[L].oc;
  assign cy = fg | (fp & {N{fc}});
  assign s_d = fx ^ {cy[N-2:0], fc};

  // Output rank holds its result until the consumer takes it
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      S <= '0;
      c_out <= 1'b0;
`ifdef SKLANSKY_ADDER_FLAGS_EN
      zero_o <= 1'b0;
      negative_o <= 1'b0;
      overflow_o <= 1'b0;
`endif
    end else if (ld[PS] && vin[PS]) begin
      S <= s_d;
      c_out <= cy[N-1];
`ifdef SKLANSKY_ADDER_FLAGS_EN
      zero_o <= (s_d == '0);
      negative_o <= s_d[N-1];
      overflow_o <= cy[N-1] ^ cy[N-2];
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_sklansky_adder.sv
// Self-checking bench for pipelined_sklansky_adder (N=64, 2 stages).
// Checks flag outputs too when SKLANSKY_ADDER_FLAGS_EN is defined.
module tb_pipelined_sklansky_adder;

  localparam int N = 64;
  localparam int PS = 2;

  logic         clock = 1'b0;
  logic         reset_n, valid_i, ready_o, c_in, sub;
  logic         valid_o, ready_i, c_out;
  logic [N-1:0] A, B, S;
`ifdef SKLANSKY_ADDER_FLAGS_EN
  logic         zero_o, negative_o, overflow_o;
`endif

  always #5 clock = ~clock;

  pipelined_sklansky_adder #(
    .INPUT_SIZE(N),
    .PIPE_STAGES(PS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .A         (A),
    .B         (B),
    .c_in      (c_in),
    .sub       (sub),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .S         (S),
    .c_out     (c_out)
`ifdef SKLANSKY_ADDER_FLAGS_EN
    ,
    .zero_o    (zero_o),
    .negative_o(negative_o),
    .overflow_o(overflow_o)
`endif
  );

  typedef struct {
    logic [N-1:0] a, b;
    logic         cin, sb;
    logic [N-1:0] s;
    logic         c, z, n, v;
  } vec_t;

  typedef struct {
    logic [N-1:0] s;
    logic         c, z, n, v;
  } exp_t;

  exp_t q[$];
  vec_t vt[10];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [N-1:0] act,
                         input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain (N+1)-bit arithmetic on the conditioned operands.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sb);
    logic [N-1:0] bx;
    logic [N:0]   sum;
    exp_t         e;
    bx = sb ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, sb ^ cin};
    e.s = sum[N-1:0];
    e.c = sum[N];
    e.z = (e.s == '0);
    e.n = e.s[N-1];
    e.v = (a[N-1] == bx[N-1]) && (e.s[N-1] != a[N-1]);
    return e;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    check_w({tag, "_s"}, S, e.s);
    check_b({tag, "_c"}, c_out, e.c);
`ifdef SKLANSKY_ADDER_FLAGS_EN
    check_b({tag, "_zero"}, zero_o, e.z);
    check_b({tag, "_neg"}, negative_o, e.n);
    check_b({tag, "_ovf"}, overflow_o, e.v);
`endif
  endtask

  function automatic logic [N-1:0] pick();
    case ($urandom_range(7))
      0: return '1;
      1: return '0;
      2: return {1'b1, {(N-1){1'b0}}};
      3: return {1'b0, {(N-1){1'b1}}};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic drive(input int pct, input bit more);
    if (more && ($urandom_range(99) < pct)) begin
      valid_i = 1'b1;
      A = pick();
      B = pick();
      c_in = 1'($urandom_range(1));
      sub = 1'($urandom_range(1));
    end else begin
      valid_i = 1'b0;
      A = {$urandom(), $urandom()};
    end
  endtask

  task automatic apply_vec(input vec_t t);
    A = t.a;
    B = t.b;
    c_in = t.cin;
    sub = t.sb;
  endtask

  task automatic run_stream(input int total, input int rdy_pct,
                            input int vld_pct, output int cycles);
    int           sent;
    bit           taken, held, done;
    logic [N-1:0] hs;
    logic         hc;
    exp_t         e;
    sent = 0;
    held = 0;
    done = 0;
    cycles = 0;
    q.delete();
    @(negedge clock);
    drive(vld_pct, sent < total);
    while (!done && cycles < total * 10 + 100) begin
      ready_i = ($urandom_range(99) < rdy_pct);
      #1;
      cycles++;
      if (held) begin
        check_b("hold_valid", valid_o, 1'b1);
        check_w("hold_s", S, hs);
        check_b("hold_c", c_out, hc);
      end
      check_b("ready_o", ready_o, !((q.size() == PS + 1) && !ready_i));
      if (valid_o && ready_i) begin
        if (q.size() == 0) check_b("extra_result", valid_o, 1'b0);
        else begin
          e = q.pop_front();
          check_out("stream", e);
        end
      end
      held = valid_o && !ready_i;
      hs = S;
      hc = c_out;
      taken = valid_i && ready_o;
      if (taken) begin
        q.push_back(model(A, B, c_in, sub));
        sent++;
      end
      done = (sent == total) && (q.size() == 0);
      @(negedge clock);
      if (taken || !valid_i) drive(vld_pct, sent < total);
    end
    if (!done) check_b("stream_timeout", done, 1'b1);
    valid_i = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, cyc;
    exp_t e;

    vt[0] = '{a: '1, b: 64'd1, cin: 0, sb: 0,
              s: '0, c: 1, z: 1, n: 0, v: 0};
    vt[1] = '{a: 64'h0123_4567_89AB_CDEF, b: 64'hFEDC_BA98_7654_3210,
              cin: 0, sb: 0, s: '1, c: 0, z: 0, n: 1, v: 0};
    vt[2] = '{a: 64'd5, b: 64'd7, cin: 0, sb: 1,
              s: 64'hFFFF_FFFF_FFFF_FFFE, c: 0, z: 0, n: 1, v: 0};
    vt[3] = '{a: 64'd7, b: 64'd5, cin: 0, sb: 1,
              s: 64'd2, c: 1, z: 0, n: 0, v: 0};
    vt[4] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, cin: 0, sb: 0,
              s: 64'h8000_0000_0000_0000, c: 0, z: 0, n: 1, v: 1};
    vt[5] = '{a: 64'h1234, b: 64'h1234, cin: 0, sb: 1,
              s: '0, c: 1, z: 1, n: 0, v: 0};
    vt[6] = '{a: '0, b: '0, cin: 1, sb: 0,
              s: 64'd1, c: 0, z: 0, n: 0, v: 0};
    vt[7] = '{a: 64'd9, b: 64'd4, cin: 1, sb: 1,
              s: 64'd4, c: 1, z: 0, n: 0, v: 0};
    vt[8] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000,
              cin: 0, sb: 0, s: '0, c: 1, z: 1, n: 0, v: 1};
    vt[9] = '{a: 64'h8000_0000_0000_0000, b: 64'd1, cin: 0, sb: 1,
              s: 64'h7FFF_FFFF_FFFF_FFFF, c: 1, z: 0, n: 0, v: 1};

    reset_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    A = '0;
    B = '0;
    c_in = 1'b0;
    sub = 1'b0;
    repeat (2) @(negedge clock);
    check_b("rst_valid", valid_o, 1'b0);
    check_w("rst_s", S, '0);
    check_b("rst_c", c_out, 1'b0);
    reset_n = 1'b1;
    #1;
    check_b("rst_ready", ready_o, 1'b1);

    // Directed vectors: single transactions with latency check
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      apply_vec(vt[i]);
      valid_i = 1'b1;
      @(negedge clock);
      valid_i = 1'b0;
      lat = 1;
      while (!valid_o && lat < 20) begin
        @(negedge clock);
        lat++;
      end
      check_i("latency", lat, PS + 1);
      e = '{s: vt[i].s, c: vt[i].c, z: vt[i].z, n: vt[i].n, v: vt[i].v};
      check_out($sformatf("vec%0d", i), e);
    end

    // Fill under backpressure, then release with simultaneous arrival
    @(negedge clock);
    ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clock);
      apply_vec(vt[k]);
      valid_i = 1'b1;
      #1;
      check_b($sformatf("fill_ready%0d", k), ready_o, k < 3);
    end
    check_b("fill_valid", valid_o, 1'b1);
    check_out("fill_head", model(vt[0].a, vt[0].b, vt[0].cin, vt[0].sb));
    @(negedge clock);
    check_b("stall_ready", ready_o, 1'b0);
    check_out("stall_head", model(vt[0].a, vt[0].b, vt[0].cin, vt[0].sb));
    ready_i = 1'b1;
    #1;
    check_b("release_ready", ready_o, 1'b1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      valid_i = 1'b0;
      check_b($sformatf("drain_valid%0d", k), valid_o, 1'b1);
      check_out($sformatf("drain%0d", k),
                model(vt[k].a, vt[k].b, vt[k].cin, vt[k].sb));
    end
    @(negedge clock);
    check_b("drain_empty", valid_o, 1'b0);

    // Back-to-back random stream: one result per cycle
    run_stream(10000, 100, 100, cyc);
    check_i("b2b_cycles", cyc, 10000 + PS + 1);

    // Random backpressure and input gaps
    run_stream(3000, 50, 70, cyc);
    run_stream(500, 25, 100, cyc);

    // Reset with three items in flight
    @(negedge clock);
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      apply_vec(vt[3]);
      valid_i = 1'b1;
    end
    @(negedge clock);
    valid_i = 1'b0;
    check_b("pre_reset_valid", valid_o, 1'b1);
    reset_n = 1'b0;
    @(negedge clock);
    check_b("mid_rst_valid", valid_o, 1'b0);
    check_w("mid_rst_s", S, '0);
    check_b("mid_rst_c", c_out, 1'b0);
    reset_n = 1'b1;
    #1;
    check_b("mid_rst_ready", ready_o, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_b($sformatf("no_stale%0d", k), valid_o, 1'b0);
    end
    run_stream(200, 60, 80, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_sklansky_adder.md
Name: pipelined_sklansky_adder

Overview:
- Parametrised, pipelined Sklansky parallel-prefix adder/subtractor with valid/ready handshakes on both sides.
- Successor to the combinational sklansky_adder.
- Used as the wide arithmetic unit in the core datapath, where multi-cycle latency is acceptable and backpressure from the consumer must be honoured.
- Adds three things the combinational adder lacks: configurable pipeline depth, subtract mode, and bubble-collapsing flow control.

Parameters:
- INPUT_SIZE, 64: operand width. Power of two, >= 2. LEVELS = log2(INPUT_SIZE) prefix levels.
- PIPE_STAGES, 2: internal register ranks inside the prefix network. Range 0..LEVELS. Out-of-range values are a synthesis-time error.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- valid_i  input  1  input operands valid.
- ready_o  output  1  block can accept an operand set this cycle.
- A  input  INPUT_SIZE  operand A.
- B  input  INPUT_SIZE  operand B.
- c_in  input  1  carry-in (add) / inverted borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- S  output  INPUT_SIZE  sum/difference.
- c_out  output  1  carry-out of the MSB (raw; in subtract, 1 = no borrow).

Behaviour:
- Operand conditioning (combinational, before level 0):
  - Bx = sub ? ~B : B
  - cx = sub ? ~c_in : c_in
  - Therefore sub=1, c_in=0 yields A-B.
- Arithmetic: {c_out,S} = A + Bx + cx, exact modulo 2^(INPUT_SIZE+1). No saturation.
- Register placement: ranks follow prefix level floor(k*LEVELS/(PIPE_STAGES+1)) for k=1..PIPE_STAGES. A final output register is always present.
- Latency: PIPE_STAGES+1 cycles from input handshake (valid_i && ready_o) to valid_o, with no stalls.
- Throughput: one result per cycle while ready_i=1.
- Flow control:
  - Each rank r has a valid bit v[r].
  - Rank r loads when v[r]==0 or rank r+1 loads. The output rank loads when !valid_o or ready_i.
  - ready_o = input rank load condition. It is combinational from ready_i through the chain, with no registered skid.
  - A bubble in any rank is collapsed by upstream data even while the output is stalled.
- Output stability: while valid_o=1 and ready_i=0, S and c_out hold their values and the transaction is not lost.
- Simultaneous events:
  - Output accepted and new data arriving in the same cycle: both complete, with no bubble inserted.
  - valid_i with ready_o=0: ignored. The upstream must hold its data.
- Reset (reset_n=0 at a clock edge):
  - All valid bits clear; valid_o=0, S=0, c_out=0.
  - In-flight data is discarded.
  - ready_o=1 in the first cycle after reset deasserts.
  - Reset mid-stream drops all transactions; none reappear afterwards.
- PIPE_STAGES=0: a single output register, latency 1.
- Data registers load only on a valid advance, so X on A/B while valid_i=0 never propagates to S.

Optional Feature:
- Macro: SKLANSKY_ADDER_FLAGS_EN.
- Defined: adds three 1-bit outputs registered alongside S, all reset to 0, all qualified by valid_o:
  - zero_o: S==0.
  - negative_o: S[MSB].
  - overflow_o: signed overflow, (A[MSB]==Bx[MSB]) && (S[MSB]!=A[MSB]).
- Undefined: the ports and their logic are absent. Everything else is identical.

Decomposition:
- Shared header macros.vh holds:
  - the log2 constant function;
  - the stage-placement function (level index of rank k);
  - the SKLANSKY_ADDER_FLAGS_EN guard.
- Natural sub-module: sklansky_prefix_level.
  - Combinational, one prefix level.
  - Parameters INPUT_SIZE and LEVEL; (G,P) in, (G,P) out.
  - Instantiated LEVELS times by generate; pipeline registers sit between instances.

Test Plan:
- N=64, PIPE_STAGES=2, ready_i=1. A=0xFFFF_FFFF_FFFF_FFFF, B=1, c_in=0, sub=0 → 3 cycles later S=0, c_out=1. With B=~A and c_in=0 → S=all-ones, c_out=0.
- sub=1, A=5, B=7, c_in=0 → S=0xFFFF_FFFF_FFFF_FFFE, c_out=0. A=7, B=5 → S=2, c_out=1.
- Back-to-back: 10,000 random {A,B,c_in,sub} with valid_i held at 1 → one result per cycle, in order. Each result matches the reference model A+Bx+cx, and the error count is 0.
- Backpressure: random ready_i at 50% duty → valid_o/S stable while stalled, no lost or duplicated results, and ready_o drops only once all ranks hold valid data.
- Reset mid-stream: assert reset_n=0 for 1 cycle with 3 items in flight → next cycle valid_o=0 and S=0; no stale results after restart.
- SKLANSKY_ADDER_FLAGS_EN defined: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 → overflow_o=1, negative_o=1, zero_o=0. A=B, sub=1, c_in=0 → zero_o=1.
